ysyx_23060184_wbu: RTL and testbench

Write-back stage of the multi-cycle core, directly downstream of the memory unit. Accepts one completed instruction per Mvalid/Wready handshake and selects the write-back value from the ALU result, load data, PC+4 or CSR read data. Commits the register-file and CSR writes and signals completion to the fetch unit through a Wvalid/Iready handshake. Keeps a 64-bit retired-instruction counter.

---
 rtl/ysyx_23060184_wbu_if.sv | 43 ++++
 rtl/ysyx_23060184_wbu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060184_wbu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_wbu_if.sv
// Bundle between the write-back stage and its neighbours: memory-stage payload,
// register-file/CSR commit port, fetch-unit retirement handshake and instret.
interface ysyx_23060184_wbu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic                      Mvalid;
  logic                      Wready;
  logic [DATA_WIDTH-1:0]     ALUResult;
  logic [DATA_WIDTH-1:0]     ReadData;
  logic [DATA_WIDTH-1:0]     PcPlus4;
  logic [DATA_WIDTH-1:0]     CsrRdata;
  logic [1:0]                ResultSrc;
  logic                      RegWrite;
  logic [REG_ADDR_WIDTH-1:0] Rd;
  logic                      CsrWrite;
  logic [CSR_ADDR_WIDTH-1:0] CsrAddr;
  logic [DATA_WIDTH-1:0]     CsrWdata;
  logic                      rf_wen;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic                      csr_wen;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0]     csr_wdata;
  logic                      Wvalid;
  logic                      Iready;
  logic [63:0]               instret;

  modport slave (
    input  Mvalid, ALUResult, ReadData, PcPlus4, CsrRdata, ResultSrc,
           RegWrite, Rd, CsrWrite, CsrAddr, CsrWdata, Iready,
    output Wready, rf_wen, rf_waddr, rf_wdata, csr_wen, csr_waddr, csr_wdata,
           Wvalid, instret
  );

  modport master (
    output Mvalid, ALUResult, ReadData, PcPlus4, CsrRdata, ResultSrc,
           RegWrite, Rd, CsrWrite, CsrAddr, CsrWdata, Iready,
    input  Wready, rf_wen, rf_waddr, rf_wdata, csr_wen, csr_waddr, csr_wdata,
           Wvalid, instret
  );
endinterface

// File: rtl/ysyx_23060184_wbu.sv
// Write-back stage: captures one instruction, strobes RF/CSR writes for one
// cycle, then holds Wvalid until the fetch unit takes the retirement.
module ysyx_23060184_wbu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060184_wbu_if.slave   wb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      accept_s;
  logic                      retire_s;
  logic [DATA_WIDTH-1:0]     wb_data_s;

  logic [DATA_WIDTH-1:0]     hold_alu_r;
  logic [DATA_WIDTH-1:0]     hold_rdata_r;
  logic [DATA_WIDTH-1:0]     hold_pc4_r;
  logic [DATA_WIDTH-1:0]     hold_csrr_r;
  logic [1:0]                hold_src_r;
  logic [REG_ADDR_WIDTH-1:0] hold_rd_r;
  logic [CSR_ADDR_WIDTH-1:0] hold_caddr_r;
  logic [DATA_WIDTH-1:0]     hold_cwdata_r;
  logic                      rf_wen_r;
  logic                      csr_wen_r;
  logic                      wvalid_r;
  logic [63:0]               instret_r;

  // Next-state logic and handshake qualifiers.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    retire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wb.Mvalid) begin
          accept_s = 1'b1;
          state_s  = COMMIT;
        end else begin
          state_s  = IDLE;
        end
      end
      COMMIT: begin
        state_s = DONE;
      end
      DONE: begin
        if (wb.Iready) begin
          retire_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s  = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Write-back source select on the captured fields.
  always_comb begin
    wb_data_s = {DATA_WIDTH{1'b0}};
    case (hold_src_r)
      2'b00:   wb_data_s = hold_alu_r;
      2'b01:   wb_data_s = hold_rdata_r;
      2'b10:   wb_data_s = hold_pc4_r;
      2'b11:   wb_data_s = hold_csrr_r;
      default: wb_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // State register, payload capture, commit strobes and retirement counter.
  // Strobes are computed at the accept edge so they are registered in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      hold_alu_r    <= {DATA_WIDTH{1'b0}};
      hold_rdata_r  <= {DATA_WIDTH{1'b0}};
      hold_pc4_r    <= {DATA_WIDTH{1'b0}};
      hold_csrr_r   <= {DATA_WIDTH{1'b0}};
      hold_src_r    <= 2'b00;
      hold_rd_r     <= {REG_ADDR_WIDTH{1'b0}};
      hold_caddr_r  <= {CSR_ADDR_WIDTH{1'b0}};
      hold_cwdata_r <= {DATA_WIDTH{1'b0}};
      rf_wen_r      <= 1'b0;
      csr_wen_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      instret_r     <= 64'd0;
    end else begin
      state_r   <= state_s;
      rf_wen_r  <= accept_s && wb.RegWrite && (wb.Rd != {REG_ADDR_WIDTH{1'b0}});
      csr_wen_r <= accept_s && wb.CsrWrite;
      wvalid_r  <= (state_s == DONE);
      if (accept_s) begin
        hold_alu_r    <= wb.ALUResult;
        hold_rdata_r  <= wb.ReadData;
        hold_pc4_r    <= wb.PcPlus4;
        hold_csrr_r   <= wb.CsrRdata;
        hold_src_r    <= wb.ResultSrc;
        hold_rd_r     <= wb.Rd;
        hold_caddr_r  <= wb.CsrAddr;
        hold_cwdata_r <= wb.CsrWdata;
      end
      if (retire_s) begin
        instret_r <= instret_r + 64'd1;
      end
    end
  end

  assign wb.Wready    = (state_r == IDLE) && !rst;
  assign wb.rf_wen    = rf_wen_r;
  assign wb.rf_waddr  = hold_rd_r;
  assign wb.rf_wdata  = wb_data_s;
  assign wb.csr_wen   = csr_wen_r;
  assign wb.csr_waddr = hold_caddr_r;
  assign wb.csr_wdata = hold_cwdata_r;
  assign wb.Wvalid    = wvalid_r;
  assign wb.instret   = instret_r;

endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Randomized scoreboard bench for the write-back stage: the driver queues the
// expected commit of each instruction, a negedge monitor checks what appears.
module tb_ysyx_23060184_wbu;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 12;

  typedef struct {
    logic          rf_wen;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          csr_wen;
    logic [CW-1:0] caddr;
    logic [DW-1:0] cdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060184_wbu_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CSR_ADDR_WIDTH(CW)) bus ();
  ysyx_23060184_wbu #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CSR_ADDR_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .wb(bus));

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_cnt = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: commit contents, strobe quietness, Wvalid/Wready protocol, instret.
  logic exp_commit = 1'b0, exp_done = 1'b0, prev_wv = 1'b0, prev_ir = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_wready", bus.Wready, 0);
      chk("rst_wvalid", bus.Wvalid, 0);
      chk("rst_rf_wen", bus.rf_wen, 0);
      chk("rst_csr_wen", bus.csr_wen, 0);
      chk("rst_instret", bus.instret, 0);
      model_cnt  = 64'd0;
      exp_commit = 1'b0;
      exp_done   = 1'b0;
      prev_wv    = 1'b0;
      prev_ir    = 1'b0;
    end else begin
      chk("instret", bus.instret, model_cnt);
      if (exp_commit) begin
        chk("commit_wready", bus.Wready, 0);
        chk("commit_wvalid", bus.Wvalid, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_queue actual=empty required=entry");
        end else begin
          e = exp_q.pop_front();
          chk("rf_wen", bus.rf_wen, e.rf_wen);
          if (e.rf_wen) begin
            chk("rf_waddr", bus.rf_waddr, e.waddr);
            chk("rf_wdata", bus.rf_wdata, e.wdata);
          end
          chk("csr_wen", bus.csr_wen, e.csr_wen);
          if (e.csr_wen) begin
            chk("csr_waddr", bus.csr_waddr, e.caddr);
            chk("csr_wdata", bus.csr_wdata, e.cdata);
          end
        end
      end else begin
        chk("quiet_rf_wen", bus.rf_wen, 0);
        chk("quiet_csr_wen", bus.csr_wen, 0);
      end
      if (exp_done) chk("wvalid_after_commit", bus.Wvalid, 1);
      if (prev_wv && !prev_ir) begin
        chk("wvalid_hold", bus.Wvalid, 1);
        chk("wready_busy", bus.Wready, 0);
      end
      if (prev_wv && prev_ir) begin
        chk("wready_after_retire", bus.Wready, 1);
        chk("wvalid_after_retire", bus.Wvalid, 0);
      end
      exp_done   = exp_commit;
      exp_commit = bus.Mvalid && bus.Wready;
      prev_wv    = bus.Wvalid;
      prev_ir    = bus.Iready;
      if (bus.Wvalid && bus.Iready) model_cnt = model_cnt + 64'd1;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.Wready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Wready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=%0b required=1", bus.Wready);
    end
  endtask

  task automatic send(input logic rw, input logic [RW-1:0] rd, input logic [1:0] src,
                      input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                      input logic [DW-1:0] pc4, input logic [DW-1:0] csrr,
                      input logic cw, input logic [CW-1:0] ca, input logic [DW-1:0] cd,
                      input int delay);
    exp_t          e;
    logic [DW-1:0] sel [4];
    wait_idle();
    @(posedge clk);
    #1;
    bus.ALUResult = alu;  bus.ReadData = rdata; bus.PcPlus4  = pc4;
    bus.CsrRdata  = csrr; bus.ResultSrc = src;  bus.RegWrite = rw;
    bus.Rd        = rd;   bus.CsrWrite = cw;    bus.CsrAddr  = ca;
    bus.CsrWdata  = cd;   bus.Mvalid   = 1'b1;  bus.Iready   = (delay == 0);
    sel[0] = alu; sel[1] = rdata; sel[2] = pc4; sel[3] = csrr;
    e.rf_wen  = rw && (rd != 5'd0);
    e.waddr   = rd;
    e.wdata   = sel[src];
    e.csr_wen = cw;
    e.caddr   = ca;
    e.cdata   = cd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    // Upstream is free to change its inputs once the payload is captured.
    bus.Mvalid    = 1'b0;
    bus.ALUResult = $urandom; bus.ReadData = $urandom; bus.PcPlus4 = $urandom;
    bus.CsrRdata  = $urandom; bus.CsrWdata = $urandom; bus.Rd = 5'($urandom);
    bus.ResultSrc = 2'($urandom); bus.RegWrite = 1'($urandom); bus.CsrWrite = 1'($urandom);
    bus.CsrAddr   = 12'($urandom);
    if (delay > 0) begin
      repeat (delay + 1) @(posedge clk);
      #1;
      bus.Iready = 1'b1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.Mvalid = 1'b0; bus.Iready = 1'b0; bus.ALUResult = 32'd0; bus.ReadData = 32'd0;
    bus.PcPlus4 = 32'd0; bus.CsrRdata = 32'd0; bus.ResultSrc = 2'd0; bus.RegWrite = 1'b0;
    bus.Rd = 5'd0; bus.CsrWrite = 1'b0; bus.CsrAddr = 12'd0; bus.CsrWdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wready", bus.Wready, 1);
    chk("post_rst_wvalid", bus.Wvalid, 0);
    chk("post_rst_instret", bus.instret, 0);
    repeat (10) @(negedge clk);

    // Directed cases: ALU write, x0 + CSR, csrrw with CSR read data, mux sweep.
    send(1'b1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0, 0);
    send(1'b1, 5'd0, 2'b00, 32'hDEAD, 32'h0, 32'h0, 32'h0, 1'b1, 12'h300, 32'h8, 0);
    send(1'b1, 5'd7, 2'b11, 32'h1, 32'h2, 32'h3, 32'h1800, 1'b1, 12'h300, 32'h8, 0);
    send(1'b1, 5'd9, 2'b01, 32'h1, 32'hFFFFFF80, 32'h3, 32'h4, 1'b0, 12'h0, 32'h0, 0);
    send(1'b1, 5'd1, 2'b10, 32'h1, 32'h2, 32'h80000004, 32'h4, 1'b0, 12'h0, 32'h0, 0);
    // Backpressure for 5 cycles in DONE.
    send(1'b1, 5'd3, 2'b00, 32'hCAFE, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0, 5);

    // instret wrap from all ones.
    wait_idle();
    @(posedge clk);
    #1;
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    model_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    release dut.instret_r;
    send(1'b1, 5'd4, 2'b00, 32'h55, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0, 0);
    wait_idle();
    @(negedge clk);
    chk("instret_wrap", bus.instret, 0);

    // Reset while the retirement is pending in DONE.
    send(1'b1, 5'd6, 2'b00, 32'h77, 32'h0, 32'h0, 32'h0, 1'b1, 12'h305, 32'h9, 20);
    n = 0;
    @(negedge clk);
    while (!bus.Wvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_wvalid", bus.Wvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_rst_wvalid", bus.Wvalid, 0);
    chk("midop_rst_rf_wen", bus.rf_wen, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.Iready = 1'b1;
    send(1'b1, 5'd10, 2'b00, 32'hABCD, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0, 0);
    wait_idle();
    @(negedge clk);
    chk("after_rst_instret", bus.instret, 1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [RW-1:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      send(1'($urandom), rd, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
           1'($urandom), 12'($urandom), $urandom, $urandom_range(0, 3));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
